alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; legal values are 8 or more.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: in_valid  input  1  an operation is presented.
REQ-005 Port: in_ready  output  1  the block accepts the operation this cycle.
REQ-006 Port: op_a, op_b  input  WIDTH  operands.
REQ-007 Port: s  input  4  function select.
REQ-008 Port: m  input  1  1 = arithmetic, 0 = logic.
REQ-009 Port: cin  input  1  carry-in.
REQ-010 Port: chain  input  1  replace op_a with the accumulator.
REQ-011 Port: out_valid  output  1  a result is presented.
REQ-012 Port: out_ready  input  1  the consumer takes the result.
REQ-013 Port: dout  output  WIDTH  result.
REQ-014 Port: c, v, n, z, err  output  1 each  carry, overflow, sign, zero, illegal-op flags of dout.
REQ-015 Port: clr_sticky  input  1  clears the sticky flags.
REQ-016 Port: sticky_v, sticky_err  output  1 each  OR of v / err over all delivered results.

Function
REQ-017 Two register stages: S1 (operand capture) and S2 (result/output); both SHALL advance together when adv = !out_valid || out_ready.
REQ-018 in_ready SHALL equal adv (combinational); transfer = in_valid && in_ready.
REQ-019 An op transferred at edge k SHALL present out_valid=1 with its result after edge k+1; latency is 2 edges with no stall; throughput is 1 op/cycle.
REQ-020 If adv=0, S1, S2, dout and all flags SHALL hold; no op is dropped or duplicated; results leave in issue order.
REQ-021 If adv=1 and S1 is empty, S2 SHALL become empty (out_valid=0) at that edge.
REQ-022 Execution SHALL happen on the S1->S2 transfer; effective A = chain ? acc : op_a, where acc is the dout of the most recently executed op (0 after reset), including an op executed at the immediately preceding edge.
REQ-023 Logic (m=0, cin ignored): s=0000 zero, 0001 ~(A|B), 0010 ~A&B, 0011 ~A, 0100 A&~B, 0101 ~B, 0110 A^B, 0111 ~(A&B), 1000 A&B, 1001 ~(A^B), 1010 B, 1011 ~A|B, 1100 A, 1101 A|~B, 1110 A|B, 1111 all ones; c=1, v=0, err=0.
REQ-024 Add (m=1, s=1001): dout = (A+B+cin) mod 2^WIDTH; c = bit WIDTH of the WIDTH+1-bit sum; v = (A[msb]==B[msb]) && (dout[msb]!=A[msb]).
REQ-025 Subtract (m=1, s=0110): dout = A+~B+cin; c = carry-out (1 = no borrow; with cin=1, c = A>=B unsigned); v = (A[msb]!=B[msb]) && (dout[msb]!=A[msb]).
REQ-026 Any other m=1 code SHALL be illegal: dout all ones, err=1, c=0, v=0; acc SHALL still update to all ones.
REQ-027 n = dout[WIDTH-1] and z = (dout==0) for every op.
REQ-028 On each output handshake (out_valid && out_ready), sticky_v |= v and sticky_err |= err.
REQ-029 clr_sticky SHALL zero the sticky flags at the edge; if a handshake occurs on the same edge, that handshake's v/err SHALL be set after the clear.

Reset
REQ-030 While rst_n=0: S1/S2 empty, out_valid=0, dout=0, c=v=n=err=0, z=1, acc=0, sticky flags=0; in_ready=1 once rst_n=1.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight ops; no result from them SHALL appear after release.

Verification
REQ-032 add, A=0x7FFFFFFF, B=1, cin=0 -> two edges later: dout 0x80000000, c=0, v=1, n=1, z=0, sticky_v=1 after the handshake.
REQ-033 sub, cin=1, A=5, B=5 -> dout 0, z=1, c=1, v=0; then A=3, B=5 -> dout 0xFFFFFFFE, c=0, n=1.
REQ-034 logic s=0110, A=0xF0F0F0F0, B=0xFF00FF00, cin=1 -> dout 0x0FF00FF0, c=1, v=0.
REQ-035 back-to-back: add 1+2, then chain add B=4, then chain sub B=7, cin=1 -> dout 3, 7, 0 (z=1) on consecutive cycles.
REQ-036 two ops in flight, out_ready=0 for 3 cycles -> in_ready=0, dout stable, both results delivered in order after release; s=0000 m=1 -> dout 0xFFFFFFFF, err=1; rst_n pulse mid-stream -> out_valid=0, acc=0.

Source files
------------

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: S1 captures operands, S2 executes and presents the result.
// Both stages advance together under a single stall signal driven by the consumer.
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cin,
    input  logic             chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             c,
    output logic             v,
    output logic             n,
    output logic             z,
    output logic             err,
    input  logic             clr_sticky,
    output logic             sticky_v,
    output logic             sticky_err
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // in_ready is combinational and equals adv; S1 and S2 move only when adv=1.

    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic [3:0] S_SUB = 4'b0110;

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [3:0]       s1_s_q;
    logic             s1_m_q;
    logic             s1_cin_q;
    logic             s1_chain_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] dout_q;
    logic             c_q;
    logic             v_q;
    logic             n_q;
    logic             z_q;
    logic             err_q;
    logic             sticky_v_q;
    logic             sticky_err_q;

    logic             adv;
    logic             out_hs;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] dout_d;
    logic             c_d;
    logic             v_d;
    logic             err_d;
    logic             sticky_v_d;
    logic             sticky_err_d;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;
    assign out_hs   = out_valid_q && out_ready;

    // dout_q holds the last executed result across bubbles and stalls, so it is the accumulator.
    assign a_eff = s1_chain_q ? dout_q : s1_a_q;
    assign b_op  = (s1_s_q == S_SUB) ? ~s1_b_q : s1_b_q;
    assign sum   = {1'b0, a_eff} + {1'b0, b_op} + {{WIDTH{1'b0}}, s1_cin_q};

    always_comb begin
        dout_d = '0;
        c_d    = 1'b0;
        v_d    = 1'b0;
        err_d  = 1'b0;
        if (!s1_m_q) begin
            c_d = 1'b1;
            case (s1_s_q)
                4'b0000: dout_d = '0;
                4'b0001: dout_d = ~(a_eff | s1_b_q);
                4'b0010: dout_d = ~a_eff & s1_b_q;
                4'b0011: dout_d = ~a_eff;
                4'b0100: dout_d = a_eff & ~s1_b_q;
                4'b0101: dout_d = ~s1_b_q;
                4'b0110: dout_d = a_eff ^ s1_b_q;
                4'b0111: dout_d = ~(a_eff & s1_b_q);
                4'b1000: dout_d = a_eff & s1_b_q;
                4'b1001: dout_d = ~(a_eff ^ s1_b_q);
                4'b1010: dout_d = s1_b_q;
                4'b1011: dout_d = ~a_eff | s1_b_q;
                4'b1100: dout_d = a_eff;
                4'b1101: dout_d = a_eff | ~s1_b_q;
                4'b1110: dout_d = a_eff | s1_b_q;
                default: dout_d = '1;
            endcase
        end else if (s1_s_q == S_ADD || s1_s_q == S_SUB) begin
            // Subtract reuses the adder with B inverted, so one overflow rule covers both.
            dout_d = sum[WIDTH-1:0];
            c_d    = sum[WIDTH];
            v_d    = (a_eff[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a_eff[WIDTH-1]);
        end else begin
            dout_d = '1;
            err_d  = 1'b1;
        end
    end

    // A clear and a same-edge handshake combine: the clear applies first.
    always_comb begin
        sticky_v_d   = (clr_sticky ? 1'b0 : sticky_v_q) | (out_hs & v_q);
        sticky_err_d = (clr_sticky ? 1'b0 : sticky_err_q) | (out_hs & err_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_s_q     <= '0;
            s1_m_q     <= 1'b0;
            s1_cin_q   <= 1'b0;
            s1_chain_q <= 1'b0;
        end else if (adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_a_q     <= op_a;
                s1_b_q     <= op_b;
                s1_s_q     <= s;
                s1_m_q     <= m;
                s1_cin_q   <= cin;
                s1_chain_q <= chain;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            n_q         <= 1'b0;
            z_q         <= 1'b1;
            err_q       <= 1'b0;
        end else if (adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                dout_q <= dout_d;
                c_q    <= c_d;
                v_q    <= v_d;
                n_q    <= dout_d[WIDTH-1];
                z_q    <= (dout_d == '0);
                err_q  <= err_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_v_q   <= 1'b0;
            sticky_err_q <= 1'b0;
        end else begin
            sticky_v_q   <= sticky_v_d;
            sticky_err_q <= sticky_err_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign dout       = dout_q;
    assign c          = c_q;
    assign v          = v_q;
    assign n          = n_q;
    assign z          = z_q;
    assign err        = err_q;
    assign sticky_v   = sticky_v_q;
    assign sticky_err = sticky_err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vectors, then random traffic against
// an arithmetic reference model with an in-order expected-result queue.
module tb_alu_pipe;

    localparam int W  = 32;
    localparam int RW = W + 5;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [3:0]    s;
    logic          m;
    logic          cin;
    logic          chain;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  dout;
    logic          c, v, n, z, err;
    logic          clr_sticky;
    logic          sticky_v;
    logic          sticky_err;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .s(s), .m(m), .cin(cin), .chain(chain),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .c(c), .v(v), .n(n), .z(z), .err(err),
        .clr_sticky(clr_sticky), .sticky_v(sticky_v), .sticky_err(sticky_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected entry layout: {dout, c, v, n, z, err}
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] got_q[$];
    int            got_cyc_q[$];
    logic [W-1:0]  m_acc;
    logic          sv_m, se_m;
    logic          stall_prev;
    logic [W-1:0]  prev_dout;
    int            cyc;
    int            n_tests;
    int            n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [RW-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [3:0] ss, input logic mm, input logic ci);
        logic [W-1:0] d;
        logic         cc, vv, ee;
        longint       ua, ub, sa, sb, ci_l, r, sr;
        ua   = longint'({32'b0, a});
        ub   = longint'({32'b0, b});
        sa   = a[W-1] ? ua - 64'sh1_0000_0000 : ua;
        sb   = b[W-1] ? ub - 64'sh1_0000_0000 : ub;
        ci_l = ci ? 64'sd1 : 64'sd0;
        d = '0; cc = 1'b1; vv = 1'b0; ee = 1'b0;
        if (!mm) begin
            case (ss)
                4'd0:  d = '0;
                4'd1:  d = ~(a | b);
                4'd2:  d = ~a & b;
                4'd3:  d = ~a;
                4'd4:  d = a & ~b;
                4'd5:  d = ~b;
                4'd6:  d = a ^ b;
                4'd7:  d = ~(a & b);
                4'd8:  d = a & b;
                4'd9:  d = ~(a ^ b);
                4'd10: d = b;
                4'd11: d = ~a | b;
                4'd12: d = a;
                4'd13: d = a | ~b;
                4'd14: d = a | b;
                default: d = '1;
            endcase
        end else if (ss == 4'd9) begin
            r  = ua + ub + ci_l;
            d  = r[W-1:0];
            cc = (r > 64'sd4294967295);
            sr = sa + sb + ci_l;
            vv = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        end else if (ss == 4'd6) begin
            r  = ua - ub - 64'sd1 + ci_l;
            d  = r[W-1:0];
            cc = (r >= 64'sd0);
            sr = sa - sb - 64'sd1 + ci_l;
            vv = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        end else begin
            d = '1; cc = 1'b0; ee = 1'b1;
        end
        return {d, cc, vv, d[W-1], (d == '0), ee};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},  64'(out_valid), 64'd0);
        check({tag, "_dout"},   64'(dout), 64'd0);
        check({tag, "_flags"},  64'({c, v, n, z, err}), 64'(5'b00010));
        check({tag, "_sticky"}, 64'({sticky_v, sticky_err}), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst");
        exp_q.delete();
        m_acc = '0; sv_m = 1'b0; se_m = 1'b0; stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] ss, input logic mm, input logic ci, input logic ch,
                        input logic ordy, input logic clr);
        logic [RW-1:0] e;
        logic          hs, tr;
        @(negedge clk);
        cyc++;
        check("sticky_v", 64'(sticky_v), 64'(sv_m));
        check("sticky_err", 64'(sticky_err), 64'(se_m));
        if (stall_prev) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_dout", 64'(dout), 64'(prev_dout));
        end
        in_valid = iv; op_a = a; op_b = b; s = ss; m = mm; cin = ci; chain = ch;
        out_ready = ordy; clr_sticky = clr;
        #1;
        check("in_ready", 64'(in_ready), 64'(!out_valid || ordy));
        hs = out_valid && ordy;
        tr = iv && in_ready;
        e  = '0;
        if (hs) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", 64'({dout, c, v, n, z, err}), 64'(e));
            end
            got_q.push_back({dout, c, v, n, z, err});
            got_cyc_q.push_back(cyc);
        end
        if (tr) begin
            e = ref_op(ch ? m_acc : a, b, ss, mm, ci);
            m_acc = e[RW-1 -: W];
            exp_q.push_back(e);
        end
        sv_m = (clr ? 1'b0 : sv_m) | (hs & (exp_q.size() >= 0) & got_q[$][3]);
        se_m = (clr ? 1'b0 : se_m) | (hs & got_q[$][0]);
        stall_prev = out_valid && !ordy;
        prev_dout  = dout;
    endtask

    task automatic idle(input int k, input logic ordy);
        for (int i = 0; i < k; i++) step(1'b0, '0, '0, 4'd0, 1'b0, 1'b0, 1'b0, ordy, 1'b0);
    endtask

    initial begin
        logic [3:0] ss;
        int         r;
        n_tests = 0; n_fail = 0; cyc = 0;
        rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; s = '0; m = 1'b0;
        cin = 1'b0; chain = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
        m_acc = '0; sv_m = 1'b0; se_m = 1'b0; stall_prev = 1'b0; prev_dout = '0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("por");
        rst_n = 1'b1;

        // Signed overflow on add
        got_q.delete(); got_cyc_q.delete();
        step(1'b1, 32'h7FFF_FFFF, 32'h1, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b1);
        check("add_ovf", 64'(got_q[0]), 64'({32'h8000_0000, 5'b01100}));
        check("add_ovf_sticky", 64'(sticky_v), 64'd1);

        // Subtract equal / borrow
        got_q.delete(); got_cyc_q.delete();
        step(1'b1, 32'd5, 32'd5, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'd3, 32'd5, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b1);
        check("sub_eq", 64'(got_q[0]), 64'({32'h0, 5'b10010}));
        check("sub_borrow", 64'(got_q[1]), 64'({32'hFFFF_FFFE, 5'b00100}));
        check("sticky_cleared", 64'(sticky_v), 64'd0);

        // Logic XOR ignores carry-in
        got_q.delete(); got_cyc_q.delete();
        step(1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b1);
        check("xor", 64'(got_q[0]), 64'({32'h0FF0_0FF0, 5'b10000}));

        // Back-to-back accumulator chain
        got_q.delete(); got_cyc_q.delete();
        step(1'b1, 32'd1, 32'd2, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'hDEAD, 32'd4, 4'b1001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'hBEEF, 32'd7, 4'b0110, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(4, 1'b1);
        check("chain0", 64'(got_q[0][RW-1 -: W]), 64'd3);
        check("chain1", 64'(got_q[1][RW-1 -: W]), 64'd7);
        check("chain2", 64'(got_q[2]), 64'({32'h0, 5'b10010}));
        check("chain_gap", 64'(got_cyc_q[2] - got_cyc_q[0]), 64'd2);

        // Stall with two ops in flight, then an illegal op
        got_q.delete(); got_cyc_q.delete();
        step(1'b1, 32'd10, 32'd20, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'd0, 32'd0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'd99, 32'd1, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        idle(4, 1'b1);
        check("stall_n", 64'(got_q.size()), 64'd2);
        check("stall_first", 64'(got_q[0][RW-1 -: W]), 64'd30);
        check("illegal", 64'(got_q[1]), 64'({32'hFFFF_FFFF, 5'b00101}));
        check("illegal_sticky", 64'(sticky_err), 64'd1);

        // Reset mid-stream discards in-flight ops and zeroes the accumulator
        step(1'b1, 32'd11, 32'd22, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'd33, 32'd44, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        got_q.delete(); got_cyc_q.delete();
        idle(3, 1'b1);
        check("rst_no_out", 64'(got_q.size()), 64'd0);
        step(1'b1, 32'hFFFF, 32'd0, 4'b1001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1);
        check("rst_acc", 64'(got_q[0][RW-1 -: W]), 64'd0);

        // Random traffic
        for (int k = 0; k < 800; k++) begin
            if (k == 400) do_reset();
            r  = int'($urandom_range(0, 3));
            ss = (r == 0) ? 4'b1001 : (r == 1) ? 4'b0110 : 4'($urandom_range(0, 15));
            step($urandom_range(0, 9) < 7, $urandom, ($urandom_range(0, 7) == 0) ? $urandom & 32'hF : $urandom,
                 ss, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
        end
        idle(6, 1'b1);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
